// File: rtl/pixel_plot_fifo.sv
// Pixel-write FIFO between the drawing datapaths and the 160x120 VGA adapter port.
// Optional feature macro: PIXEL_CLIP_COUNT_EN adds the clip_count output.
module pixel_plot_fifo #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_x,
   input  logic [6:0]    in_y,
   input  logic [2:0]    in_colour,
   input  logic          pause,
   output logic [7:0]    vga_x,
   output logic [6:0]    vga_y,
   output logic [2:0]    vga_colour,
   output logic          vga_plot,
   output logic [AW:0]   level,
`ifdef PIXEL_CLIP_COUNT_EN
   output logic [15:0]   clip_count,
`endif
   output logic          overflow
);

   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [7:0]    X_LIM    = 8'(SCREEN_W);
   localparam logic [6:0]    Y_LIM    = 7'(SCREEN_H);

   logic [17:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [17:0]   head;
   logic          on_screen;
   logic          accept;
   logic          push;
   logic          pop;

`ifdef PIXEL_CLIP_COUNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Handshake decode: ready comes from registered level only, so a pop
   // in the same cycle never frees a slot for a full FIFO.
   assign in_ready  = (level != FULL_LVL);
   assign on_screen = (in_x < X_LIM) && (in_y < Y_LIM);
   assign accept    = in_valid && in_ready;
   assign push      = accept && on_screen;
   assign pop       = (level != '0) && !pause;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {in_x, in_y, in_colour};
      end
   end

   // Output stage: registered pixel and one-cycle plot strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr                      <= rd_ptr + PTR_ONE;
            {vga_x, vga_y, vga_colour}  <= head;
         end
         vga_plot <= pop;
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef PIXEL_CLIP_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         clip_count <= '0;
      end else if (accept && !on_screen) begin
         clip_count <= sat_inc16(clip_count);
      end
   end
`endif

endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Directed bench for pixel_plot_fifo: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_pixel_plot_fifo;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic [6:0]  in_y;
   logic [2:0]  in_colour;
   logic        pause;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic [4:0]  level;
   logic        overflow;
`ifdef PIXEL_CLIP_COUNT_EN
   logic [15:0] clip_count;
`endif

   pixel_plot_fifo dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .pause      (pause),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .level      (level),
`ifdef PIXEL_CLIP_COUNT_EN
      .clip_count (clip_count),
`endif
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of on-screen pixels.
   logic [17:0] q[$];
   logic [17:0] dut_log[$];
   logic [7:0]  m_x;
   logic [6:0]  m_y;
   logic [2:0]  m_c;
   logic        m_plot;
   logic        m_ovf;
   logic [15:0] m_clip;
   int          max_lvl;

   always @(posedge clock) begin
      int   sz;
      logic [17:0] pix;
      if (reset) begin
         q.delete();
         m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_ovf = 0; m_clip = 0;
      end else begin
         sz = q.size();
         if (sz != 0 && !pause) begin
            pix = q.pop_front();
            {m_x, m_y, m_c} = pix;
            m_plot = 1'b1;
         end else begin
            m_plot = 1'b0;
         end
         if (in_valid && sz != DEPTH) begin
            if (in_x < 8'd160 && in_y < 7'd120) q.push_back({in_x, in_y, in_colour});
            else if (m_clip != 16'hFFFF) m_clip = m_clip + 16'd1;
         end
         if (in_valid && sz == DEPTH) m_ovf = 1'b1;
      end
      #1;
      chk("cycle", {vga_plot, vga_x, vga_y, vga_colour, level, in_ready, overflow},
          {m_plot, m_x, m_y, m_c, 5'(q.size()), (q.size() != DEPTH), m_ovf});
`ifdef PIXEL_CLIP_COUNT_EN
      chk("clip_count", clip_count, m_clip);
`endif
      if (vga_plot) dut_log.push_back({vga_x, vga_y, vga_colour});
      if (int'(level) > max_lvl) max_lvl = int'(level);
   end

   // Offer one pixel starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      logic ok;
      int   n;
      in_valid = 1'b1; in_x = x; in_y = y; in_colour = c;
      n = 0;
      do begin
         ok = in_ready;
         @(negedge clock);
         n++;
      end while (!ok && n < 100);
      if (!ok) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0; pause = 1'b0;
      max_lvl = 0;
      repeat (3) @(negedge clock);
      chk("rst_level", level, 5'd0);
      chk("rst_plot", vga_plot, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      reset = 1'b0;

      // 1: single pixel, one-cycle plot strobe
      dut_log.delete();
      send(8'd5, 7'd7, 3'd3);
      chk("t1_plot_now", vga_plot, 1'b0);
      idle(1);
      chk("t1_plot_strobe", vga_plot, 1'b1);
      chk("t1_pix_out", {vga_x, vga_y, vga_colour}, {8'd5, 7'd7, 3'd3});
      idle(2);
      chk("t1_count", dut_log.size(), 1);
      chk("t1_level", level, 5'd0);

      // 2: fill to full, overflow, drain in order
      dut_log.delete();
      pause = 1'b1;
      for (int i = 0; i < 16; i++) send(8'(i), 7'd0, 3'(i));
      in_valid = 1'b0;
      chk("t2_full_level", level, 5'd16);
      chk("t2_full_ready", in_ready, 1'b0);
      in_valid = 1'b1; in_x = 8'd99; in_y = 7'd1; in_colour = 3'd7;
      @(negedge clock);
      in_valid = 1'b0;
      chk("t2_overflow", overflow, 1'b1);
      chk("t2_level_kept", level, 5'd16);
      pause = 1'b0;
      idle(20);
      chk("t2_count", dut_log.size(), 16);
      for (int i = 0; i < 16; i++) chk("t2_order", dut_log[i], {8'(i), 7'd0, 3'(i)});
      chk("t2_ovf_sticky", overflow, 1'b1);

      // 3: clipping
      dut_log.delete();
      max_lvl = 0;
      send(8'd160, 7'd0, 3'd1);
      send(8'd0, 7'd120, 3'd2);
      send(8'd159, 7'd119, 3'd5);
      idle(4);
      chk("t3_count", dut_log.size(), 1);
      chk("t3_pix", dut_log[0], {8'd159, 7'd119, 3'd5});
      chk("t3_maxlvl", max_lvl, 1);
`ifdef PIXEL_CLIP_COUNT_EN
      chk("t3_clip", clip_count, 16'd2);
`endif

      // 4: full-screen sweep
      pulse_reset();
      dut_log.delete();
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++) send(8'(x), 7'(y), 3'((x + y) % 8));
      idle(4);
      chk("t4_count", dut_log.size(), 19200);
      chk("t4_last", dut_log[dut_log.size() - 1], {8'd159, 7'd119, 3'd6});
      chk("t4_overflow", overflow, 1'b0);

      // 5: reset discards stored pixels
      pause = 1'b1;
      for (int i = 0; i < 8; i++) send(8'(i + 20), 7'(i), 3'(i));
      in_valid = 1'b0;
      chk("t5_level_pre", level, 5'd8);
      pulse_reset();
      chk("t5_level", level, 5'd0);
      chk("t5_plot", vga_plot, 1'b0);
      chk("t5_ready", in_ready, 1'b1);
      dut_log.delete();
      pause = 1'b0;
      idle(10);
      chk("t5_no_plots", dut_log.size(), 0);

      // 6: steady state at level 3, push and pop every cycle
      dut_log.delete();
      pause = 1'b1;
      for (int k = 0; k < 3; k++) send(8'(k + 10), 7'(k), 3'(k % 8));
      pause = 1'b0;
      for (int k = 3; k < 43; k++) send(8'(k + 10), 7'(k), 3'(k % 8));
      in_valid = 1'b0;
      pause = 1'b1;
      chk("t6_level", level, 5'd3);
      pause = 1'b0;
      idle(5);
      chk("t6_count", dut_log.size(), 43);
      for (int k = 0; k < 43; k++) chk("t6_order", dut_log[k], {8'(k + 10), 7'(k), 3'(k % 8)});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
